// File: rtl/router_reg_gen.sv
// Router register stage: latches the header, buffers one byte while the FIFO is full,
// accumulates parity and checks parity/payload length. Optional ROUTER_REG_STATS_EN adds counters.
module router_reg_gen #(
    parameter int unsigned DW           = 8,
    parameter int unsigned AW           = 2,
    parameter int unsigned ILLEGAL_ADDR = 2**AW - 1,
    parameter int unsigned ODD_PAR      = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pkt_vld,
    input  logic [DW-1:0] din,
    input  logic          fifo_full,
    input  logic          rst_int_reg,
    input  logic          detect_addr,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          lfd_state,
    input  logic          full_state,
    output logic          parity_done,
    output logic          low_pkt_valid,
    output logic          err,
    output logic          len_err,
    output logic [DW-1:0] d_out
`ifdef ROUTER_REG_STATS_EN
    ,
    output logic [15:0]   pkt_cnt,
    output logic [15:0]   err_cnt
`endif
);

    localparam int unsigned LW = DW - AW;

    logic [DW-1:0] hdr_q, hdr_d;
    logic [DW-1:0] hold_q, hold_d;
    logic [DW-1:0] int_par_q, int_par_d;
    logic [DW-1:0] pkt_par_q, pkt_par_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [LW-1:0] pay_cnt_q, pay_cnt_d;
    logic          lpv_q, lpv_d;
    logic          pd_q, pd_d;
    logic          chk_q, chk_d;
    logic          err_q, err_d;
    logic          len_q, len_d;

    logic          par_from_din_c;
    logic          par_from_hold_c;
    logic          cnt_inc_c;
    logic [DW-1:0] exp_par_c;
    logic          par_bad_c;
    logic          len_bad_c;

    // Next-state logic for the whole datapath
    always_comb begin
        hdr_d     = hdr_q;
        hold_d    = hold_q;
        int_par_d = int_par_q;
        pkt_par_d = pkt_par_q;
        dout_d    = dout_q;
        pay_cnt_d = pay_cnt_q;
        lpv_d     = lpv_q;
        pd_d      = pd_q;
        err_d     = err_q;
        len_d     = len_q;

        par_from_din_c  = ld_state && !fifo_full && !pkt_vld;
        par_from_hold_c = laf_state && lpv_q && !pd_q;
        cnt_inc_c       = (ld_state && pkt_vld && !fifo_full) || (laf_state && !lpv_q);
        exp_par_c       = (ODD_PAR != 0) ? ~int_par_q : int_par_q;
        par_bad_c       = exp_par_c != pkt_par_q;
        len_bad_c       = pay_cnt_q != hdr_q[DW-1:AW];

        if (detect_addr && pkt_vld && (din[AW-1:0] != AW'(ILLEGAL_ADDR)))
            hdr_d = din;

        if (ld_state && fifo_full)
            hold_d = din;

        if (lfd_state)
            dout_d = hdr_q;
        else if (ld_state && !fifo_full)
            dout_d = din;
        else if (laf_state)
            dout_d = hold_q;

        if (ld_state && !pkt_vld)
            lpv_d = 1'b1;
        if (rst_int_reg)
            lpv_d = 1'b0;

        if (par_from_din_c || par_from_hold_c)
            pd_d = 1'b1;
        if (detect_addr)
            pd_d = 1'b0;

        if (par_from_din_c)
            pkt_par_d = din;
        else if (par_from_hold_c)
            pkt_par_d = hold_q;

        // Bytes re-presented during FIFO_FULL/LAF were already folded in on their LOAD_DATA cycle
        if (detect_addr)
            int_par_d = '0;
        else if (lfd_state)
            int_par_d = int_par_q ^ hdr_q;
        else if (ld_state && pkt_vld && !full_state)
            int_par_d = int_par_q ^ din;

        if (detect_addr)
            pay_cnt_d = '0;
        else if (cnt_inc_c && (pay_cnt_q != {LW{1'b1}}))
            pay_cnt_d = pay_cnt_q + LW'(1);

        if (chk_q) begin
            err_d = par_bad_c;
            len_d = len_bad_c;
        end
        if (detect_addr) begin
            err_d = 1'b0;
            len_d = 1'b0;
        end

        chk_d = pd_d && !pd_q;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            hdr_q     <= '0;
            hold_q    <= '0;
            int_par_q <= '0;
            pkt_par_q <= '0;
            dout_q    <= '0;
            pay_cnt_q <= '0;
            lpv_q     <= 1'b0;
            pd_q      <= 1'b0;
            chk_q     <= 1'b0;
            err_q     <= 1'b0;
            len_q     <= 1'b0;
        end else begin
            hdr_q     <= hdr_d;
            hold_q    <= hold_d;
            int_par_q <= int_par_d;
            pkt_par_q <= pkt_par_d;
            dout_q    <= dout_d;
            pay_cnt_q <= pay_cnt_d;
            lpv_q     <= lpv_d;
            pd_q      <= pd_d;
            chk_q     <= chk_d;
            err_q     <= err_d;
            len_q     <= len_d;
        end
    end

    assign parity_done   = pd_q;
    assign low_pkt_valid = lpv_q;
    assign err           = err_q;
    assign len_err       = len_q;
    assign d_out         = dout_q;

`ifdef ROUTER_REG_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating packet/error statistics, untouched by detect_addr
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        err_cnt_d = err_cnt_q;
        if (chk_d && (pkt_cnt_q != 16'hFFFF))
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        if (chk_q && !detect_addr && (par_bad_c || len_bad_c) && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/router_reg_gen.md
Name: router_reg_gen

Overview:
Parametrised next-generation router register stage. It sits between the router input FSM and the per-destination FIFOs.
- Latches the header, buffers one byte while the FIFO is full, and forwards bytes on d_out.
- Accumulates packet parity and compares it against the trailing parity byte.
- New in this generation: generic data width, generic address-field width, selectable even/odd parity, and a payload-length checker (len_err) driven by the header length field.

Parameters:
- DW, 8, data/byte width in bits.
- AW, 2, width of the header address field, header[AW-1:0]; length field is header[DW-1:AW].
- ILLEGAL_ADDR, 2**AW-1, address value that is never latched as a valid header.
- ODD_PAR, 0, 0 = even parity (XOR of all bytes), 1 = odd parity (inverted XOR).

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous active-low reset
- pkt_vld  in  1  source byte valid; deasserted on the parity byte
- din  in  DW  incoming byte
- fifo_full  in  1  destination FIFO full
- rst_int_reg  in  1  clears low_pkt_valid
- detect_addr  in  1  FSM in DECODE_ADDRESS
- ld_state  in  1  FSM in LOAD_DATA
- laf_state  in  1  FSM in LOAD_AFTER_FULL
- lfd_state  in  1  FSM in LOAD_FIRST_DATA
- full_state  in  1  FSM in FIFO_FULL_STATE
- parity_done  out  1  parity byte captured
- low_pkt_valid  out  1  end of packet seen by the load path
- err  out  1  parity mismatch
- len_err  out  1  payload count differs from header length
- d_out  out  DW  byte to FIFO

Behaviour:
- All regs update on posedge clk. On rstn==0, all outputs and internal regs go to 0: hdr, hold, int_par, pkt_par, pay_cnt, chk_pend.
- hdr: loads din when detect_addr && pkt_vld && din[AW-1:0] != ILLEGAL_ADDR; otherwise holds.
- d_out, in priority order:
  - lfd_state: d_out <= hdr.
  - ld_state && !fifo_full: d_out <= din.
  - laf_state: d_out <= hold.
  - Otherwise hold.
- hold: loads din when ld_state && fifo_full.
- low_pkt_valid: set when ld_state && !pkt_vld. Cleared when rst_int_reg. If both occur in the same cycle, clear wins.
- parity_done:
  - Set when ld_state && !fifo_full && !pkt_vld.
  - Also set when laf_state && low_pkt_valid && !parity_done.
  - Cleared when detect_addr; clear wins over set.
- pkt_par: loads din when ld_state && !fifo_full && !pkt_vld. Loads hold when laf_state && low_pkt_valid && !parity_done.
- int_par:
  - Cleared by detect_addr.
  - lfd_state: int_par <= int_par ^ hdr.
  - ld_state && pkt_vld && !full_state: int_par ^= din.
  - Otherwise hold.
  - With ODD_PAR=1, the comparison uses ~int_par.
- pay_cnt (DW-AW bits):
  - Cleared by detect_addr.
  - Increments on ld_state && pkt_vld && !fifo_full.
  - Also increments on laf_state when the held byte is payload, i.e. !low_pkt_valid.
  - Saturates at all-ones; no wrap.
- chk_pend: set in the cycle parity_done rises, cleared the next cycle. Evaluation happens in that one cycle after parity_done rises:
  - err <= (expected parity != pkt_par).
  - len_err <= (pay_cnt != hdr[DW-1:AW]).
- err and len_err hold until detect_addr clears them; clear has priority.
- Reset mid-packet returns all state to 0. No residual parity or count carries into the next header.
- Zero-length header (length 0): a parity byte immediately after the header is legal, giving len_err=0.
- Latency: header appears on d_out 1 cycle after lfd_state. Payload appears 1 cycle after its ld_state cycle. err/len_err are valid 1 cycle after parity_done.

Optional Feature:
Macro ROUTER_REG_STATS_EN.
- Defined: adds outputs pkt_cnt[15:0] and err_cnt[15:0].
  - pkt_cnt increments on each parity_done rising edge.
  - err_cnt increments when err or len_err is evaluated as 1.
  - Both saturate at 16'hFFFF, reset to 0 on rstn, and are not cleared by detect_addr.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, DW=8/AW=2: send header 8'h3A (len 14, addr 2), 14 random payloads, correct even parity, fifo_full=0 -> d_out sequence matches, parity_done=1, err=0, len_err=0.
- Same packet with corrupted parity byte (correct^8'h01) -> err=1 one cycle after parity_done, len_err=0; next detect_addr clears err.
- Header 8'h14 (len 5) but only 4 payloads sent -> len_err=1, err=0 when parity is correct.
- Assert fifo_full on payload 3 (din=8'hA5), FSM goes full_state then laf_state -> hold=8'hA5, d_out=8'hA5 in laf; int_par unaffected by duplicates; err=0.
- Header with addr 2'b11 (8'h0B) under detect_addr -> hdr unchanged; assert rstn=0 mid-payload -> all outputs 0 next cycle.
- ODD_PAR=1, DW=16, AW=3: header 16'h0052 (len 10, addr 2), 10 payloads, parity = ~XOR -> err=0; parity sent as plain XOR -> err=1.
